// File: rtl/tm_pkg.sv
// Shared definitions for the TM CADU framing path: sync marker, PN randomizer
// constants, framer state encoding and small byte helpers.
package tm_pkg;

  // CCSDS attached sync marker, transmitted MSB byte first
  localparam logic [31:0] CCSDS_ASM = 32'h1ACFFC1D;

  // Randomizer seed (all ones) and tap mask for h(x)=x^8+x^7+x^5+x^3+1.
  // Bit i of the mask selects the LFSR window bit holding sequence bit a[n+i].
  localparam logic [7:0] PN_SEED = 8'hFF;
  localparam logic [7:0] PN_POLY = 8'hA9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ASM  = 2'd1,
    DATA = 2'd2
  } tm_state_e;

  // Select one marker byte, index 0 being the most significant byte
  function automatic logic [7:0] asm_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  // Bit-reverse a byte
  function automatic logic [7:0] bit_rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/tm_pn_gen.sv
// CCSDS pseudo-random sequence generator, one output byte per advance.
// The window register holds the next 8 sequence bits with the oldest bit in
// bit 0; the presented byte is that window reversed so the first generated
// bit appears as the MSB. Each advance runs the recurrence 8 times.
module tm_pn_gen
  import tm_pkg::*;
(
  input  logic       clk,
  input  logic       nGrst,
  input  logic       rst,
  input  logic       seed_ld,
  input  logic       adv,
  output logic [7:0] pn_byte
);

  logic [7:0] win;

  // Eight unrolled LFSR steps: new bit = parity of tapped window bits
  function automatic logic [7:0] step8(input logic [7:0] w);
    logic [7:0] r;
    r = w;
    for (int i = 0; i < 8; i++) r = {^(r & PN_POLY), r[7:1]};
    return r;
  endfunction

  // Window register: reseed on reset or request, else advance one byte
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      win <= PN_SEED;
    end else if (rst || seed_ld) begin
      win <= PN_SEED;
    end else if (adv) begin
      win <= step8(win);
    end
  end

  assign pn_byte = bit_rev8(win);

endmodule

// File: rtl/tm_cadu_framer.sv
// CADU framer: prefixes each RS codeblock with the 32-bit ASM and XORs the
// codeblock bytes with the CCSDS pseudo-random sequence.
// Build option: define TM_RANDOMIZER_EN to enable the randomizer; without it
// codeblock bytes pass through unchanged and the PN generator is absent.
//
// Handshake (both sides): a byte moves on a clock edge where valid & ready are
// both high. The source holds data stable while valid & !ready; ready never
// depends combinationally on the partner's valid. The output register only
// loads when it is empty or being drained (!out_valid | out_ready).
module tm_cadu_framer
  import tm_pkg::*;
#(
  parameter int unsigned BLK_LEN  = 255,
  parameter logic [31:0] ASM_WORD = CCSDS_ASM,
  parameter int unsigned CNT_W    = 9
) (
  input  logic       clk,
  input  logic       nGrst,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eof,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_LEN - 1);

  tm_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             last_byte;
  logic [7:0]       pn_byte;

  assign load      = !out_valid || out_ready;
  assign in_ready  = (state == DATA) && load;
  assign last_byte = (cnt == LAST_IDX);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

`ifdef TM_RANDOMIZER_EN
  logic accept;
  logic seed_ld;

  assign accept  = in_valid && in_ready;
  // Reseed on every entry into ASM, from IDLE or straight from a block end
  assign seed_ld = ((state == IDLE) && en && in_valid) ||
                   (accept && last_byte && en);

  tm_pn_gen u_pn_gen (
    .clk     (clk),
    .nGrst   (nGrst),
    .rst     (rst),
    .seed_ld (seed_ld),
    .adv     (accept),
    .pn_byte (pn_byte)
  );
`else
  assign pn_byte = 8'h00;
`endif

  // Framing FSM with registered output byte and sof/eof qualifiers
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Drain any held final byte, then wait for a block to present itself
          if (load) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
          end
          if (en && in_valid) begin
            state <= ASM;
            cnt   <= '0;
          end
        end
        ASM: begin
          if (load) begin
            out_data  <= asm_byte(ASM_WORD, cnt[1:0]);
            out_valid <= 1'b1;
            out_sof   <= (cnt == '0);
            out_eof   <= 1'b0;
            if (cnt[1:0] == 2'd3) begin
              state <= DATA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (load) begin
            if (in_valid) begin
              out_data  <= in_data ^ pn_byte;
              out_valid <= 1'b1;
              out_sof   <= 1'b0;
              out_eof   <= last_byte;
              if (last_byte) begin
                cnt   <= '0;
                state <= (en && in_valid) ? ASM : IDLE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              // Input starved: let the pending byte go and show a bubble
              out_valid <= 1'b0;
              out_sof   <= 1'b0;
              out_eof   <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
